// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_matrix_scanner                                                    |
// | Scans a 4x4 key matrix by column, debounces full frames, reports presses. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module keypad_matrix_scanner #(
    parameter int F_CLK           = 50000000,
    parameter int F_SCAN          = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] key_state,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_multi,
    output logic        key_any
);

    localparam int DIV   = F_CLK / F_SCAN;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIV - 1);
    localparam logic [3:0]       c_deb      = 4'(DEBOUNCE_FRAMES);

    localparam logic [0:0] S_SCAN = 1'b0;
    localparam logic [0:0] S_EVAL = 1'b1;

    generate
        if (DIV < 4) begin : g_div_check
            $error("keypad_matrix_scanner: F_CLK/F_SCAN must be >= 4");
        end
        if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_deb_check
            $error("keypad_matrix_scanner: DEBOUNCE_FRAMES must be 1..15");
        end
    endgenerate

    // Reset asserts asynchronously but leaves reset on a clock edge.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       arst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign arst_n = rst_sync_q[1];

    logic [3:0]       row_meta_q, row_meta_d;
    logic [3:0]       row_sync_q, row_sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [15:0]      frame_q, frame_d;
    logic [0:0]       state_q, state_d;
    logic [15:0]      cand_q, cand_d;
    logic [3:0]       match_q, match_d;
    logic [15:0]      key_state_q, key_state_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_multi_q, key_multi_d;

    logic [15:0] new_press;
    logic [3:0]  low_idx;
    logic [4:0]  pop_cnt;

    always_comb begin
        new_press = frame_q & ~key_state_q;
        low_idx   = 4'd0;
        pop_cnt   = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (new_press[i]) begin
                low_idx = 4'(i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            pop_cnt = pop_cnt + {4'd0, new_press[i]};
        end
    end

    always_comb begin
        row_meta_d  = row_n;
        row_sync_d  = row_meta_q;
        cnt_d       = cnt_q + 1'b1;
        col_d       = col_q;
        frame_d     = frame_q;
        state_d     = S_SCAN;
        cand_d      = cand_q;
        match_d     = match_q;
        key_state_d = key_state_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_multi_d = key_multi_q;

        if (cnt_q == c_cnt_last) begin
            cnt_d = '0;
            case (col_q)
                2'd0:    frame_d[3:0]   = ~row_sync_q;
                2'd1:    frame_d[7:4]   = ~row_sync_q;
                2'd2:    frame_d[11:8]  = ~row_sync_q;
                default: frame_d[15:12] = ~row_sync_q;
            endcase
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
                state_d = S_EVAL;
            end
        end

        // The next column-0 sample is at least DIV cycles away, so frame_q is whole here.
        if (state_q == S_EVAL) begin
            if (frame_q != cand_q) begin
                cand_d  = frame_q;
                match_d = 4'd1;
            end else if (match_q < c_deb) begin
                match_d = match_q + 4'd1;
            end
            if (match_d == c_deb && frame_q != key_state_q) begin
                key_state_d = frame_q;
                if (|new_press) begin
                    key_valid_d = 1'b1;
                    key_code_d  = low_idx;
                    key_multi_d = (pop_cnt > 5'd1);
                end
            end
        end

        col_n_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            cnt_q       <= '0;
            col_q       <= 2'd0;
            col_n_q     <= 4'b1110;
            frame_q     <= 16'h0000;
            state_q     <= S_SCAN;
            cand_q      <= 16'h0000;
            match_q     <= 4'd0;
            key_state_q <= 16'h0000;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_multi_q <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            col_n_q     <= col_n_d;
            frame_q     <= frame_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            match_q     <= match_d;
            key_state_q <= key_state_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_multi_q <= key_multi_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_state = key_state_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_multi = key_multi_q;
    assign key_any   = |key_state_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keypad_matrix_scanner                                                 |
// | Keypad model, press-event scoreboard and directed/random scenarios.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_keypad_matrix_scanner;

    localparam int F_CLK   = 40;
    localparam int F_SCAN  = 10;
    localparam int DEB     = 3;
    localparam int FRAME   = 16;
    localparam int LAT_MAX = (DEB + 1) * FRAME + 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] key_state;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_multi;
    logic        key_any;

    keypad_matrix_scanner #(
        .F_CLK(F_CLK), .F_SCAN(F_SCAN), .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .key_state(key_state), .key_valid(key_valid), .key_code(key_code),
        .key_multi(key_multi), .key_any(key_any)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
    logic [15:0] keys;
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_n[c] && keys[c*4 + r]) row_n[r] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [3:0]  code;
        logic        multi;
        logic [15:0] state;
        int          push_cyc;
        int          min_lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_state;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: a stable change from model_state to nw produces one event for the new presses.
    task automatic apply_keys(input logic [15:0] nw, input int min_lat);
        logic [15:0] newp;
        exp_t        e;
        newp = nw & ~model_state;
        keys = nw;
        if (newp != 16'h0) begin
            e.code = 4'd0;
            for (int i = 15; i >= 0; i--) if (newp[i]) e.code = 4'(i);
            e.multi    = ($countones(newp) > 1);
            e.state    = nw;
            e.push_cyc = cyc;
            e.min_lat  = min_lat;
            sb.push_back(e);
        end
        model_state = nw;
    endtask

    exp_t mon_e;
    int   mon_lat;
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_key_valid actual code=%0d required no pulse", key_code);
                end else begin
                    mon_e   = sb.pop_front();
                    mon_lat = cyc - mon_e.push_cyc;
                    check("key_code", 32'(key_code), 32'(mon_e.code));
                    check("key_multi", 32'(key_multi), 32'(mon_e.multi));
                    check("key_state_at_event", 32'(key_state), 32'(mon_e.state));
                    check("key_any_at_event", 32'(key_any), 32'(|mon_e.state));
                    checks++;
                    if (mon_lat > LAT_MAX || mon_lat < mon_e.min_lat) begin
                        failures++;
                        $display("FAIL event_latency actual=%0d required=%0d..%0d",
                                 mon_lat, mon_e.min_lat, LAT_MAX);
                    end
                end
            end else if (sb.size() > 0 && (cyc - sb[0].push_cyc) > LAT_MAX) begin
                checks++;
                failures++;
                $display("FAIL event_timeout actual=no key_valid required code=%0d", sb[0].code);
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(posedge clk);
        #1;
    endtask

    task automatic check_settled(input string name);
        @(negedge clk);
        check({name, "_key_state"}, 32'(key_state), 32'(model_state));
        check({name, "_key_any"}, 32'(key_any), 32'(|model_state));
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_col_n"}, 32'(col_n), 32'h0000000E);
        check({name, "_key_state"}, 32'(key_state), 32'd0);
        check({name, "_key_valid"}, 32'(key_valid), 32'd0);
        check({name, "_key_code"}, 32'(key_code), 32'd0);
        check({name, "_key_multi"}, 32'(key_multi), 32'd0);
        check({name, "_key_any"}, 32'(key_any), 32'd0);
    endtask

    task automatic random_phase();
        repeat ($urandom_range(0, FRAME - 1)) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  exp_col_n;
        logic [15:0] rnd;
        int          ecol;

        rst_n       = 1'b0;
        keys        = 16'h0;
        model_state = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Scenario 1: column walk after reset release.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk);
            @(negedge clk);
            ecol      = (k < 2) ? 0 : ((k - 2) / 4) % 4;
            exp_col_n = 4'b1111;
            exp_col_n[ecol] = 1'b0;
            check("col_n_walk", 32'(col_n), 32'(exp_col_n));
        end
        wait_frames(8);
        check_settled("idle");

        // Scenario 2: single steady press, then release.
        random_phase();
        apply_keys(16'h0040, 0);
        wait_frames(8);
        check_settled("key6");
        apply_keys(16'h0000, 0);
        wait_frames(6);
        check_settled("key6_release");

        // Scenario 3: bouncing key 9 settles pressed.
        random_phase();
        keys[9] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            repeat (5) @(posedge clk);
            #1;
            keys[9] = ~keys[9];
        end
        repeat (2) @(posedge clk);
        #1;
        apply_keys(16'h0200, 0);
        wait_frames(8);
        check_settled("key9");
        apply_keys(16'h0000, 0);
        wait_frames(6);
        check_settled("key9_release");

        // Scenario 4/5: two simultaneous presses, then staged releases.
        random_phase();
        apply_keys(16'h1008, 0);
        wait_frames(8);
        check_settled("keys3_12");
        apply_keys(16'h1000, 0);
        wait_frames(6);
        check_settled("release3");
        apply_keys(16'h0000, 0);
        wait_frames(6);
        check_settled("release12");

        // Scenario 6: reset during debounce of key 15 restarts the debounce.
        random_phase();
        keys = 16'h8000;
        repeat (FRAME + 6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        model_state = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_keys(16'h8000, DEB * FRAME);
        wait_frames(8);
        check_settled("key15");
        apply_keys(16'h0000, 0);
        wait_frames(6);
        check_settled("key15_release");

        // Random sparse key maps held long enough to commit.
        for (int n = 0; n < 14; n++) begin
            random_phase();
            rnd = 16'($urandom) & 16'($urandom) & 16'($urandom);
            apply_keys(rnd, 0);
            wait_frames(6);
            check_settled("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Input-side counterpart of the scanned 7-segment display driver: drives a 4x4 key-matrix column-by-column and reads the row lines back.
- Debounces the full 16-key snapshot and emits a one-cycle press event with a 4-bit key code.
- Sits between the board key matrix and the counter/control logic, replacing per-pin key debouncers where a matrix keypad is fitted.

Parameters:
- F_CLK, 50000000, system clock frequency in Hz.
- F_SCAN, 1000, column step rate in Hz. DIV = F_CLK/F_SCAN clocks per column; DIV must be >= 4 (elaboration error otherwise).
- DEBOUNCE_FRAMES, 4, number of consecutive identical full-matrix frames required to commit a new key state; range 1..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- row_n  input  4  matrix row lines, active-low (pulled up off-chip), asynchronous to clk.
- col_n  output  4  matrix column drive, active-low one-hot.
- key_state  output  16  debounced pressed map; bit index = col*4 + row, 1 = pressed.
- key_valid  output  1  one-clk pulse on a debounced new press.
- key_code  output  4  lowest index among newly pressed keys; updated only with key_valid, held otherwise.
- key_multi  output  1  with key_valid: more than one new press in the same commit; held otherwise.
- key_any  output  1  |key_state.

Behaviour:
- Reset (async assert, sync deassert): col_n=4'b1110 (column 0), dwell cnt=0, col=0, key_state=0, key_valid=0, key_code=0, key_multi=0, key_any=0, candidate=0, match_cnt=0, row sync flops=4'b1111.
- Row sync: row_n passes through a 2-flop synchronizer; all sampling uses the synchronized value, inverted to active-high.
- Scan counter: cnt counts 0..DIV-1 per column.
- At the edge where cnt==DIV-1:
  - the synced rows are written into frame bits [col*4+3 : col*4];
  - col advances 0->1->2->3->0 (wraps);
  - col_n changes on that same edge;
  - cnt returns to 0.
- Settle time: rows are sampled DIV-1 cycles after the column change, so DIV>=4 guarantees at least one settled synced sample.
- Frame FSM (SCAN -> EVAL -> SCAN):
  - Sampling column 3 (edge E) completes the frame and enters EVAL for exactly one cycle.
  - Scanning continues uninterrupted during EVAL.
- EVAL (edge E+1):
  - If frame != candidate: candidate<=frame, match_cnt<=1.
  - Else if match_cnt < DEBOUNCE_FRAMES: match_cnt<=match_cnt+1.
  - Commit fires when the resulting match_cnt equals DEBOUNCE_FRAMES and frame != key_state: key_state<=frame.
  - match_cnt saturates at DEBOUNCE_FRAMES. No re-commit while the frame is unchanged.
- Press event on commit: newp = frame & ~key_state(old).
  - If newp != 0: key_valid=1 for the single cycle following E+1; key_code = index of lowest set bit of newp; key_multi = (popcount(newp) > 1).
  - Release-only commits update key_state and key_any; they do not assert key_valid.
- key_any follows key_state combinationally from registers; it has no extra latency.
- Press latency: from a stable pin change to key_valid is at most (DEBOUNCE_FRAMES+1) frames + 2 sync cycles + 2 cycles.
- A bouncing key resets match_cnt to 1 on every mismatching frame, so no commit happens until it has been stable.
- Simultaneous press of key A and release of key B in one commit: key_valid for A only; key_state reflects both changes.
- Ghosting (3+ keys forming a rectangle) is not resolved; the raw matrix reading is reported.
- Reset mid-frame: the partial frame is discarded and scanning restarts at column 0, cnt=0. No key_valid is produced by reset.

Test Plan:
Bench parameters: F_CLK=40, F_SCAN=10 (DIV=4, frame=16 clks), DEBOUNCE_FRAMES=3. The keypad model drives row_n low when the pressed key's column is active.

1. Reset release -> col_n cycles 1110,1101,1011,0111 every 4 clks and wraps; key_state=0; no key_valid over 10 frames.
2. Press key 6 (col1,row2) steady -> after 3 identical frames, single key_valid with key_code=6, key_multi=0, key_state=16'h0040, key_any=1. No further pulses while held.
3. Key 9 bounces (toggled every 5 clks for 2 frames), then steady -> no key_valid during bounce; exactly one key_valid with code 9 three frames after it settles.
4. Keys 3 and 12 pressed in the same frame -> one key_valid with key_code=3, key_multi=1, key_state=16'h1008.
5. Hold key 12 and release key 3 -> key_state=16'h1000, no key_valid. Then release key 12 -> key_state=0, key_any=0, no key_valid.
6. Press key 15 and assert rst_n=0 during frame 2 of debounce, then release reset -> outputs at reset values immediately; after release, key_valid with code 15 only after 3 fresh frames.
